// File: rtl/sigma_delta_pkg.sv
// rtl/sigma_delta_pkg.sv - shared types and helpers for the sigma-delta DAC front end
package sigma_delta_pkg;

    typedef enum logic [1:0] {
        MUTED     = 2'd0,
        RAMP_UP   = 2'd1,
        PLAY      = 2'd2,
        RAMP_DOWN = 2'd3
    } dac_ctrl_state_t;

    function automatic int unsigned midscale(input int unsigned width);
        return 32'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/sd_sample_fifo.sv
// rtl/sd_sample_fifo.sv - power-of-two sample FIFO with registered level, no bypass
module sd_sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Both gates look at the registered level only, so a full FIFO rejects a
    // write even when a pop happens in the same cycle.
    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/sigma_delta_dac_ctrl.sv
// rtl/sigma_delta_dac_ctrl.sv - sample scheduler and soft-mute ramp; SIGMA_DELTA_DAC_CTRL_STATS_EN adds underflow_count
module sigma_delta_dac_ctrl
    import sigma_delta_pkg::*;
#(
    parameter int DAC_BITLEN  = 16,
    parameter int FIFO_DEPTH  = 8,
    parameter int PRIME_LEVEL = 4,
    parameter int RAMP_BITS   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [DAC_BITLEN-1:0]         s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic                          dac_ready,
    output logic [DAC_BITLEN-1:0]         dac_input,
    output dac_ctrl_state_t               state,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underflow
`ifdef SIGMA_DELTA_DAC_CTRL_STATS_EN
    ,
    output logic [15:0]                   underflow_count
`endif
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = DAC_BITLEN + RAMP_BITS + 2;
    localparam logic [DAC_BITLEN-1:0] MID       = DAC_BITLEN'(midscale(DAC_BITLEN));
    localparam logic [RAMP_BITS:0]    GAIN_FULL = {1'b1, {RAMP_BITS{1'b0}}};
    localparam logic [LW-1:0]         PRIME_LVL = LW'(PRIME_LEVEL);

    dac_ctrl_state_t          state_q;
    dac_ctrl_state_t          state_d;
    logic [RAMP_BITS:0]       gain_q;
    logic [RAMP_BITS:0]       gain_d;
    logic [DAC_BITLEN-1:0]    last_q;
    logic                     underflow_q;
    logic                     tick;
    logic                     pop_req;
    logic                     starved;
    logic [DAC_BITLEN-1:0]    rd_data;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [DAC_BITLEN-1:0]    sample;
    logic signed [DAC_BITLEN:0] delta;
    logic signed [PW-1:0]     prod;
    logic signed [PW-1:0]     scaled;
    logic [DAC_BITLEN-1:0]    out_d;

    assign tick      = dac_ready;
    assign pop_req   = tick && (state_q != MUTED);
    assign starved   = pop_req && fifo_empty;
    assign s_ready   = !fifo_full;
    assign state     = state_q;
    assign underflow = underflow_q;

    sd_sample_fifo #(
        .WIDTH (DAC_BITLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (s_valid),
        .wr_data (s_data),
        .pop     (pop_req),
        .rd_data (rd_data),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        if (tick) begin
            case (state_q)
                MUTED: begin
                    if (enable && (fifo_level >= PRIME_LVL)) begin
                        state_d = RAMP_UP;
                    end
                end
                RAMP_UP: begin
                    if (!enable) begin
                        state_d = RAMP_DOWN;
                    end else begin
                        gain_d = gain_q + 1'b1;
                        if (gain_d == GAIN_FULL) begin
                            state_d = PLAY;
                        end
                    end
                end
                PLAY: begin
                    gain_d = GAIN_FULL;
                    if (!enable) begin
                        state_d = RAMP_DOWN;
                        gain_d  = GAIN_FULL - 1'b1;
                    end
                end
                RAMP_DOWN: begin
                    if (enable) begin
                        state_d = RAMP_UP;
                    end else if (gain_q == '0) begin
                        // Reached via an abort at the very start of a ramp-up.
                        state_d = MUTED;
                    end else begin
                        gain_d = gain_q - 1'b1;
                        if (gain_d == '0) begin
                            state_d = MUTED;
                        end
                    end
                end
                default: state_d = MUTED;
            endcase
        end
    end

    // On a starved pop the previous sample is replayed at the new gain.
    assign sample = fifo_empty ? last_q : rd_data;
    assign delta  = $signed({1'b0, sample}) - $signed({1'b0, MID});
    assign prod   = $signed({{(PW - DAC_BITLEN - 1){delta[DAC_BITLEN]}}, delta})
                  * $signed({{(PW - RAMP_BITS - 1){1'b0}}, gain_d});
    assign scaled = prod >>> RAMP_BITS;
    assign out_d  = MID + scaled[DAC_BITLEN-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= MUTED;
            gain_q      <= '0;
            dac_input   <= MID;
            last_q      <= MID;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gain_q      <= gain_d;
            underflow_q <= starved;
            if (tick) begin
                dac_input <= (state_q == MUTED) ? MID : out_d;
            end
            if (pop_req && !fifo_empty) begin
                last_q <= rd_data;
            end
        end
    end

`ifdef SIGMA_DELTA_DAC_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            underflow_count <= '0;
        end else if (starved && (underflow_count != 16'hFFFF)) begin
            underflow_count <= underflow_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sigma_delta_dac_ctrl.sv
// tb/tb_sigma_delta_dac_ctrl.sv - self-checking bench: ramp vectors, corner sequences, random vs reference model
module tb_sigma_delta_dac_ctrl;
    import sigma_delta_pkg::*;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int PRIME = 4;
    localparam int RB    = 2;
    localparam int FS    = 4;
    localparam int MID   = 32768;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst = 1'b0;
    logic            enable = 1'b0;
    logic [DW-1:0]   s_data = '0;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic            dac_ready = 1'b0;
    logic [DW-1:0]   dac_input;
    dac_ctrl_state_t state;
    logic [3:0]      fifo_level;
    logic            underflow;
`ifdef SIGMA_DELTA_DAC_CTRL_STATS_EN
    logic [15:0]     underflow_count;
`endif

    sigma_delta_dac_ctrl #(
        .DAC_BITLEN  (DW),
        .FIFO_DEPTH  (DEPTH),
        .PRIME_LEVEL (PRIME),
        .RAMP_BITS   (RB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .dac_ready  (dac_ready),
        .dac_input  (dac_input),
        .state      (state),
        .fifo_level (fifo_level),
        .underflow  (underflow)
`ifdef SIGMA_DELTA_DAC_CTRL_STATS_EN
        ,
        .underflow_count (underflow_count)
`endif
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: queue of samples, integer gain, spec-level rules.
    int              mq[$];
    int              mgain = 0;
    int              mdac  = MID;
    int              mlast = MID;
    int              mcnt  = 0;
    bit              mund  = 1'b0;
    dac_ctrl_state_t mst   = MUTED;

    typedef struct {
        logic [15:0]       smp;
        logic [0:3][15:0]  exp;
    } ramp_vec_t;

    ramp_vec_t rv[4];

    task automatic chk(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int  smp;
        bit  pushed;
        if (rst) begin
            mq.delete();
            mgain = 0; mdac = MID; mlast = MID; mcnt = 0; mund = 1'b0; mst = MUTED;
            return;
        end
        pushed = s_valid && (mq.size() < DEPTH);
        mund   = 1'b0;
        if (dac_ready && mst == MUTED) begin
            if (enable && mq.size() >= PRIME) mst = RAMP_UP;
            mdac = MID;
        end else if (dac_ready) begin
            if (mq.size() > 0) begin
                smp   = mq.pop_front();
                mlast = smp;
            end else begin
                smp  = mlast;
                mund = 1'b1;
                if (mcnt < 65535) mcnt++;
            end
            case (mst)
                RAMP_UP: begin
                    if (!enable) mst = RAMP_DOWN;
                    else begin
                        mgain++;
                        if (mgain == FS) mst = PLAY;
                    end
                end
                PLAY: begin
                    if (!enable) begin mst = RAMP_DOWN; mgain = FS - 1; end
                end
                default: begin
                    if (enable) mst = RAMP_UP;
                    else if (mgain == 0) mst = MUTED;
                    else begin
                        mgain--;
                        if (mgain == 0) mst = MUTED;
                    end
                end
            endcase
            mdac = MID + (((smp - MID) * mgain) >>> RB);
        end
        if (pushed) mq.push_back(int'(s_data));
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        @(negedge clk);
        chk("model_dac_input", int'(dac_input), mdac);
        chk("model_state", int'(state), int'(mst));
        chk("model_fifo_level", int'(fifo_level), mq.size());
        chk("model_s_ready", int'(s_ready), int'(mq.size() < DEPTH));
        chk("model_underflow", int'(underflow), int'(mund));
`ifdef SIGMA_DELTA_DAC_CTRL_STATS_EN
        chk("model_underflow_count", int'(underflow_count), mcnt);
`endif
        dac_ready = 1'b0;
        rst       = 1'b0;
    endtask

    task automatic tick();
        repeat (7) cyc();
        dac_ready = 1'b1;
        cyc();
    endtask

    task automatic push(input logic [15:0] v);
        s_valid = 1'b1;
        s_data  = v;
        cyc();
        s_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enable = 1'b0;
        s_valid = 1'b0;
        cyc();
    endtask

    initial begin
        rv[0] = '{smp: 16'hC000, exp: {16'h9000, 16'hA000, 16'hB000, 16'hC000}};
        rv[1] = '{smp: 16'h0000, exp: {16'h6000, 16'h4000, 16'h2000, 16'h0000}};
        rv[2] = '{smp: 16'hFFFF, exp: {16'h9FFF, 16'hBFFF, 16'hDFFF, 16'hFFFF}};
        rv[3] = '{smp: 16'h7FFF, exp: {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF}};

        @(negedge clk);
        do_reset();
        chk("reset_dac", int'(dac_input), 16'h8000);
        chk("reset_state", int'(state), int'(MUTED));
        chk("reset_level", int'(fifo_level), 0);
        chk("reset_s_ready", int'(s_ready), 1);
        chk("reset_underflow", int'(underflow), 0);

        // Priming: three samples are not enough to leave MUTED.
        for (int i = 0; i < 3; i++) push(16'hC000);
        enable = 1'b1;
        tick();
        chk("prime3_state", int'(state), int'(MUTED));
        chk("prime3_dac", int'(dac_input), 16'h8000);
        chk("prime3_level", int'(fifo_level), 3);
        push(16'hC000);
        tick();
        chk("prime4_state", int'(state), int'(RAMP_UP));
        chk("prime4_level", int'(fifo_level), 4);

        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int i = 0; i < 8; i++) push(rv[r].smp);
            enable = 1'b1;
            tick();
            chk("ramp_enter_state", int'(state), int'(RAMP_UP));
            chk("ramp_enter_dac", int'(dac_input), 16'h8000);
            for (int k = 0; k < 4; k++) begin
                tick();
                chk($sformatf("ramp%0d_step%0d", r, k), int'(dac_input), int'(rv[r].exp[k]));
            end
            chk("ramp_play_state", int'(state), int'(PLAY));
        end

        // Mute ramp, then direction reversal mid-ramp.
        do_reset();
        for (int i = 0; i < 8; i++) push(16'hC000);
        enable = 1'b1;
        repeat (5) tick();
        for (int i = 0; i < 4; i++) push(16'hC000);
        enable = 1'b0;
        tick(); chk("mute_1", int'(dac_input), 16'hB000);
        tick(); chk("mute_2", int'(dac_input), 16'hA000);
        tick(); chk("mute_3", int'(dac_input), 16'h9000);
        tick(); chk("mute_4", int'(dac_input), 16'h8000);
        chk("mute_state", int'(state), int'(MUTED));
        chk("mute_level_kept", int'(fifo_level), 4);
        enable = 1'b1;
        repeat (3) tick();
        chk("rev_up_dac", int'(dac_input), 16'hA000);
        enable = 1'b0;
        tick();
        chk("rev_down_state", int'(state), int'(RAMP_DOWN));
        chk("rev_down_dac", int'(dac_input), 16'hA000);
        enable = 1'b1;
        tick();
        chk("rev_up_state", int'(state), int'(RAMP_UP));
        chk("rev_up_hold", int'(dac_input), 16'hA000);
        tick();
        chk("rev_up_step", int'(dac_input), 16'hB000);

        // Underflow after the FIFO drains in PLAY, then reset mid-PLAY.
        do_reset();
        for (int i = 0; i < 8; i++) push(16'h9000 + 16'(i * 256));
        enable = 1'b1;
        repeat (9) tick();
        chk("drain_dac", int'(dac_input), 16'h9700);
        chk("drain_level", int'(fifo_level), 0);
        tick();
        chk("uf_pulse", int'(underflow), 1);
        chk("uf_dac_repeat", int'(dac_input), 16'h9700);
`ifdef SIGMA_DELTA_DAC_CTRL_STATS_EN
        chk("uf_count", int'(underflow_count), 1);
`endif
        cyc();
        chk("uf_pulse_end", int'(underflow), 0);
        push(16'h1111);
        rst = 1'b1;
        cyc();
        chk("rst_play_dac", int'(dac_input), 16'h8000);
        chk("rst_play_level", int'(fifo_level), 0);
        chk("rst_play_state", int'(state), int'(MUTED));

        // Full FIFO: no write bypass when a pop lands on the same cycle.
        do_reset();
        for (int i = 0; i < 4; i++) push(16'hA000);
        enable = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) push(16'hA100);
        chk("full_s_ready", int'(s_ready), 0);
        chk("full_level", int'(fifo_level), 8);
        s_valid = 1'b1;
        s_data  = 16'h1234;
        dac_ready = 1'b1;
        cyc();
        s_valid = 1'b0;
        chk("full_pop_level", int'(fifo_level), 7);
        chk("full_pop_s_ready", int'(s_ready), 1);

        // Randomized traffic checked cycle by cycle against the model.
        do_reset();
        begin
            int rate = 2;
            for (int c = 0; c < 4000; c++) begin
                if (c % 256 == 0) rate = $urandom_range(0, 3);
                if ($urandom_range(0, 999) == 0) rst = 1'b1;
                if ($urandom_range(0, 63) == 0) enable = ~enable;
                case (rate)
                    0: s_valid = ($urandom_range(0, 15) == 0);
                    1: s_valid = ($urandom_range(0, 7) == 0);
                    2: s_valid = ($urandom_range(0, 1) == 0);
                    default: s_valid = ($urandom_range(0, 7) != 0);
                endcase
                s_data    = 16'($urandom);
                dac_ready = (c % 8 == 7);
                cyc();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
